// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM data port.
// slave is the arbiter's view; master is the view of the requesters and the RAM.
interface memory_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  req_a;
   logic                  lock_a;
   logic                  we_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] wdata_a;
   logic                  gnt_a;
   logic                  rvalid_a;
   logic [DATA_WIDTH-1:0] rdata_a;

   logic                  req_b;
   logic                  lock_b;
   logic                  we_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] wdata_b;
   logic                  gnt_b;
   logic                  rvalid_b;
   logic [DATA_WIDTH-1:0] rdata_b;

   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_write_enable;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;

   modport slave (
      input  req_a, lock_a, we_a, addr_a, wdata_a,
      input  req_b, lock_b, we_b, addr_b, wdata_b,
      input  mem_data_out,
      output gnt_a, rvalid_a, rdata_a,
      output gnt_b, rvalid_b, rdata_b,
      output mem_address, mem_write_enable, mem_data_in
   );

   modport master (
      output req_a, lock_a, we_a, addr_a, wdata_a,
      output req_b, lock_b, we_b, addr_b, wdata_b,
      output mem_data_out,
      input  gnt_a, rvalid_a, rdata_a,
      input  gnt_b, rvalid_b, rdata_b,
      input  mem_address, mem_write_enable, mem_data_in
   );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for the shared RAM data port, with ownership locking and a lock timeout.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate priority after every IDLE grant.
module memory_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LOCK_MAX   = 16
) (
   input logic             clock_i,
   input logic             reset_ni,
   memory_arbiter_if.slave bus_io
);
   localparam int unsigned CntW = $clog2(LOCK_MAX);
   typedef logic [CntW-1:0] cnt_t;
   localparam cnt_t CntLast = cnt_t'(LOCK_MAX - 1);
   localparam logic PrioA = 1'b0;
   localparam logic PrioB = 1'b1;

   typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

   state_e state_q, state_d;
   logic   prio_q, prio_d;
   cnt_t   lock_cnt_q, lock_cnt_d, cnt_inc;
   logic   rvalid_a_q, rvalid_a_d;
   logic   rvalid_b_q, rvalid_b_d;
   logic   gnt_a, gnt_b;

   // Grant decision; held low while reset is asserted.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus_io.req_a && (!bus_io.req_b || prio_q == PrioA)) begin
               gnt_a = 1'b1;
            end else if (bus_io.req_b) begin
               gnt_b = 1'b1;
            end
         end
         StOwnA:  gnt_a = bus_io.req_a;
         StOwnB:  gnt_b = bus_io.req_b;
         default: ;
      endcase
      if (!reset_ni) begin
         gnt_a = 1'b0;
         gnt_b = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      lock_cnt_d = lock_cnt_q;
      cnt_inc    = (lock_cnt_q == CntLast) ? lock_cnt_q : lock_cnt_q + cnt_t'(1);
      rvalid_a_d = gnt_a && !bus_io.we_a;
      rvalid_b_d = gnt_b && !bus_io.we_b;
      case (state_q)
         StIdle: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (gnt_a) begin
               prio_d = PrioB;
            end else if (gnt_b) begin
               prio_d = PrioA;
            end
`else
            // A forced-release override lasts only for this one IDLE cycle.
            prio_d = PrioA;
`endif
            if (gnt_a && bus_io.lock_a) begin
               state_d    = StOwnA;
               lock_cnt_d = '0;
            end else if (gnt_b && bus_io.lock_b) begin
               state_d    = StOwnB;
               lock_cnt_d = '0;
            end
         end
         StOwnA: begin
            lock_cnt_d = cnt_inc;
            if (!bus_io.req_a) begin
               state_d = StIdle;
            end else if (cnt_inc == CntLast) begin
               state_d = StIdle;
               prio_d  = PrioB;
            end else if (!bus_io.lock_a) begin
               state_d = StIdle;
            end
         end
         StOwnB: begin
            lock_cnt_d = cnt_inc;
            if (!bus_io.req_b) begin
               state_d = StIdle;
            end else if (cnt_inc == CntLast) begin
               state_d = StIdle;
               prio_d  = PrioA;
            end else if (!bus_io.lock_b) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_io.mem_address      = {ADDR_WIDTH{1'b0}};
      bus_io.mem_data_in      = {DATA_WIDTH{1'b0}};
      bus_io.mem_write_enable = 1'b0;
      if (gnt_a) begin
         bus_io.mem_address      = bus_io.addr_a;
         bus_io.mem_data_in      = bus_io.wdata_a;
         bus_io.mem_write_enable = bus_io.we_a;
      end else if (gnt_b) begin
         bus_io.mem_address      = bus_io.addr_b;
         bus_io.mem_data_in      = bus_io.wdata_b;
         bus_io.mem_write_enable = bus_io.we_b;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= StIdle;
         prio_q     <= PrioA;
         lock_cnt_q <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
      end
   end

   assign bus_io.gnt_a    = gnt_a;
   assign bus_io.gnt_b    = gnt_b;
   assign bus_io.rvalid_a = rvalid_a_q;
   assign bus_io.rvalid_b = rvalid_b_q;
   // The RAM's registered read already lines up with rvalid.
   assign bus_io.rdata_a  = bus_io.mem_data_out;
   assign bus_io.rdata_b  = bus_io.mem_data_out;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed test-plan steps, then random traffic against an
// ownership/budget model of the arbitration rules, with a small RAM model on the data port.
module tb_memory_arbiter;
   localparam int LM = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ram_clear = 1'b1;
   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LOCK_MAX(LM)) dut (
      .clock_i (clk),
      .reset_ni(rst_n),
      .bus_io  (bus)
   );

   logic [15:0] ram [256];
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
      end else if (bus.mem_write_enable) begin
         ram[bus.mem_address[7:0]] <= bus.mem_data_in;
      end
      bus.mem_data_out <= ram[bus.mem_address[7:0]];
   end

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: owner 0 = none, 1 = A, 2 = B; pref 1 = A, 2 = B.
   int          m_owner, m_used, m_pref, last_w;
   logic        exp_rv_a, exp_rv_b;
   logic [15:0] exp_rd_a, exp_rd_b;
   logic [15:0] shadow [256];
   logic        o_gnt_a, o_gnt_b, o_we, o_rv_a, o_rv_b;
   logic [15:0] o_addr, o_wd, o_rd_a, o_rd_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic r, input logic l, input logic w, input logic [15:0] ad,
                        input logic [15:0] wd);
      bus.req_a = r; bus.lock_a = l; bus.we_a = w; bus.addr_a = ad; bus.wdata_a = wd;
   endtask

   task automatic set_b(input logic r, input logic l, input logic w, input logic [15:0] ad,
                        input logic [15:0] wd);
      bus.req_b = r; bus.lock_b = l; bus.we_b = w; bus.addr_b = ad; bus.wdata_b = wd;
   endtask

   task automatic update_owner(input int w);
      logic lk;
      int   other;
      lk    = (w == 1) ? bus.lock_a : bus.lock_b;
      other = 3 - w;
      if (w == 0) begin
         if (m_owner != 0) m_owner = 0;
`ifndef MEM_ARB_ROUND_ROBIN_EN
         else m_pref = 1;
`endif
      end else if (m_owner == 0) begin
         if (lk) begin
            m_owner = w;
            m_used  = 1;
         end
`ifdef MEM_ARB_ROUND_ROBIN_EN
         m_pref = other;
`else
         m_pref = 1;
`endif
      end else begin
         m_used++;
         if (m_used >= LM) begin
            m_owner = 0;
            m_pref  = other;
         end else if (!lk) begin
            m_owner = 0;
         end
      end
   endtask

   // Inputs are already applied (posedge + 1); checks at negedge, model then advances.
   task automatic cycle();
      int          w;
      logic        e_we;
      logic [15:0] e_addr, e_wd;
      @(negedge clk);
      if (!rst_n) begin
         exp_rv_a = 1'b0;
         exp_rv_b = 1'b0;
      end
      w = 0;
      if (rst_n) begin
         if (m_owner == 0) begin
            if (bus.req_a && (!bus.req_b || m_pref == 1)) w = 1;
            else if (bus.req_b) w = 2;
         end else if (m_owner == 1) begin
            if (bus.req_a) w = 1;
         end else if (bus.req_b) begin
            w = 2;
         end
      end
      e_we   = (w == 1) ? bus.we_a    : (w == 2) ? bus.we_b    : 1'b0;
      e_addr = (w == 1) ? bus.addr_a  : (w == 2) ? bus.addr_b  : 16'h0;
      e_wd   = (w == 1) ? bus.wdata_a : (w == 2) ? bus.wdata_b : 16'h0;
      o_gnt_a = bus.gnt_a; o_gnt_b = bus.gnt_b; o_we = bus.mem_write_enable;
      o_addr  = bus.mem_address; o_wd = bus.mem_data_in;
      o_rv_a  = bus.rvalid_a; o_rv_b = bus.rvalid_b;
      o_rd_a  = bus.rdata_a; o_rd_b = bus.rdata_b;
      chk("gnt_a", o_gnt_a, w == 1);
      chk("gnt_b", o_gnt_b, w == 2);
      chk("mem_we", o_we, e_we);
      chk("mem_addr", o_addr, e_addr);
      chk("mem_wdata", o_wd, e_wd);
      chk("rvalid_a", o_rv_a, exp_rv_a);
      chk("rvalid_b", o_rv_b, exp_rv_b);
      if (exp_rv_a) chk("rdata_a", o_rd_a, exp_rd_a);
      if (exp_rv_b) chk("rdata_b", o_rd_b, exp_rd_b);
      if (!rst_n) begin
         m_owner = 0; m_used = 0; m_pref = 1;
      end else begin
         exp_rv_a = (w == 1) && !bus.we_a;
         exp_rv_b = (w == 2) && !bus.we_b;
         exp_rd_a = shadow[bus.addr_a[7:0]];
         exp_rd_b = shadow[bus.addr_b[7:0]];
         if (w != 0 && e_we) shadow[e_addr[7:0]] = e_wd;
         update_owner(w);
      end
      last_w = w;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random();
      rst_n = ($urandom_range(0, 199) != 0);
      if (!(bus.req_a && last_w != 1)) begin
         set_a(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               16'($urandom_range(0, 15)), 16'($urandom));
      end
      if (!(bus.req_b && last_w != 2)) begin
         set_b(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      m_owner = 0; m_used = 0; m_pref = 1; last_w = 0;
      exp_rv_a = 1'b0; exp_rv_b = 1'b0; exp_rd_a = '0; exp_rd_b = '0;
      set_a(1, 0, 0, 16'd1, 16'd0);
      set_b(1, 0, 1, 16'd3, 16'h55);
      @(posedge clk);
      #1;
      repeat (3) cycle();
      chk("rst_gnt_a", o_gnt_a, 1'b0);
      ram_clear = 1'b0;
      rst_n = 1'b1;
      set_a(0, 0, 0, 16'd0, 16'd0);
      set_b(0, 0, 0, 16'd0, 16'd0);
      cycle();

      // Single write then read by B
      set_b(1, 0, 1, 16'd5, 16'h1234);
      cycle();
      chk("wr_gnt_b", o_gnt_b, 1'b1);
      chk("wr_we", o_we, 1'b1);
      set_b(1, 0, 0, 16'd5, 16'h0);
      cycle();
      set_b(0, 0, 0, 16'd0, 16'h0);
      cycle();
      chk("rd_rvalid_b", o_rv_b, 1'b1);
      chk("rd_rdata_b", o_rd_b, 16'h1234);
      chk("rd_rvalid_a", o_rv_a, 1'b0);

      // Contention for 6 cycles
      set_a(1, 0, 0, 16'd1, 16'd0);
      set_b(1, 0, 0, 16'd2, 16'd0);
      for (int i = 0; i < 6; i++) begin
         cycle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
         chk("cont_gnt_a", o_gnt_a, (i % 2) == 0);
         chk("cont_gnt_b", o_gnt_b, (i % 2) == 1);
`else
         chk("cont_gnt_a", o_gnt_a, 1'b1);
         chk("cont_gnt_b", o_gnt_b, 1'b0);
`endif
      end
      set_a(0, 0, 0, 16'd0, 16'd0);
      set_b(0, 0, 0, 16'd0, 16'd0);
      cycle();

      // Lock by A for 3 reads while B waits
      set_a(1, 1, 0, 16'd3, 16'd0);
      set_b(1, 0, 0, 16'd4, 16'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("lock_gnt_a", o_gnt_a, 1'b1);
         chk("lock_gnt_b", o_gnt_b, 1'b0);
      end
      set_a(0, 0, 0, 16'd0, 16'd0);
      cycle();
      chk("drop_gnt_b", o_gnt_b, 1'b0);
      cycle();
      chk("after_drop_gnt_b", o_gnt_b, 1'b1);
      set_b(0, 0, 0, 16'd0, 16'd0);
      cycle();

      // Lock timeout: A holds lock forever, B waits
      set_a(1, 1, 0, 16'd6, 16'd0);
      set_b(1, 0, 0, 16'd7, 16'd0);
      for (int i = 0; i < LM; i++) begin
         cycle();
         chk("to_gnt_a", o_gnt_a, 1'b1);
         chk("to_gnt_b", o_gnt_b, 1'b0);
      end
      cycle();
      chk("to_release_gnt_b", o_gnt_b, 1'b1);
      chk("to_release_gnt_a", o_gnt_a, 1'b0);
      set_a(0, 0, 0, 16'd0, 16'd0);
      set_b(0, 0, 0, 16'd0, 16'd0);
      cycle();

      // Reset in the cycle after a granted read in OWN_A
      set_a(1, 1, 0, 16'd8, 16'd0);
      cycle();
      cycle();
      rst_n = 1'b0;
      set_a(0, 0, 0, 16'd0, 16'd0);
      set_b(1, 0, 0, 16'd9, 16'd0);
      cycle();
      chk("rst_rvalid_a", o_rv_a, 1'b0);
      chk("rst_gnt_b", o_gnt_b, 1'b0);
      rst_n = 1'b1;
      cycle();
      chk("post_rst_gnt_b", o_gnt_b, 1'b1);
      set_b(0, 0, 0, 16'd0, 16'd0);
      cycle();

      // Idle bus
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_we", o_we, 1'b0);
         chk("idle_addr", o_addr, 16'h0);
         chk("idle_gnt", {o_gnt_a, o_gnt_b}, 2'b00);
         chk("idle_rvalid", {o_rv_a, o_rv_b}, 2'b00);
      end

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         drive_random();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
